grayscale_window_3x3: RTL and testbench
=======================================

Name: grayscale_window_3x3

Overview:
- Consumes the cropped 8-bit grayscale pixel stream from the DDR3 crop reader on pclk, in raster order with valid/ready.
- Builds 3x3 neighbourhoods from two line buffers and a 3x3 register array.
- Emits one window per interior pixel to the block-matching / census stage, tagged with centre coordinates and frame/line markers.

Parameters:
frame_width, 240, pixels per line (equals the reader's crop_width)
frame_lines, 480, lines per frame
pix_width, 8, bits per pixel

Ports:
pclk  in  1  pixel clock
pclk_reset_n  in  1  asynchronous, active-low reset
pixel_data  in  pix_width  input pixel
pixel_valid  in  1  input pixel valid
pixel_ready  out  1  input ready, combinational
frame_sync  in  1  synchronous pulse; restarts raster counters at (0,0)
window_data  out  9*pix_width  3x3 window; element (r,c) at [pix_width*(3r+c) +: pix_width]; r=0 top (oldest line), c=0 left (oldest column)
window_valid  out  1  output valid
window_ready  in  1  downstream ready
window_x  out  $clog2(frame_width)  centre column
window_y  out  $clog2(frame_lines)  centre line
window_sof  out  1  first window of frame
window_eol  out  1  last window of line
window_eof  out  1  last window of frame

Behaviour:
- Clocking and reset: one clock, pclk. pclk_reset_n is asynchronous and active-low.
- Reset state: x, y, window_valid, window_x, window_y, window_sof, window_eol, window_eof and the 3x3 registers all 0. Line-buffer contents are undefined after reset.
- Handshake:
  - pixel_ready = !window_valid || window_ready.
  - An input is accepted when pixel_valid && pixel_ready.
  - An output transfers when window_valid && window_ready.
  - pixel_ready is 1 immediately after reset.
- Counters:
  - x increments on each accept and wraps at frame_width-1 to 0.
  - On wrap, y increments and wraps at frame_lines-1 to 0, giving a free-running frame.
- Line buffers:
  - lb0 holds line y-1; lb1 holds line y-2.
  - Each is frame_width x pix_width, with synchronous write and asynchronous read at address x.
- On accept:
  - The column registers shift left (c0<=c1, c1<=c2).
  - New column c2 = {lb1[x], lb0[x], pixel_data}, with the top row coming from lb1.
  - Then lb1[x]<=lb0[x] and lb0[x]<=pixel_data, same cycle.
- Window emit: on an accept with x>=2 and y>=2, registered outputs update on the next edge (latency 1 cycle):
  - window_valid<=1, window_data<=the shifted array, window_x<=x-1, window_y<=y-1.
  - window_sof<=(x==2 && y==2).
  - window_eol<=(x==frame_width-1).
  - window_eof<=(x==frame_width-1 && y==frame_lines-1).
- Non-emitting accepts (x<2 or y<2): line buffers and registers update but no window is produced. Per frame the block emits (frame_width-2)*(frame_lines-2) windows.
- Output holds: if an output transfers with no new emit, window_valid<=0. window_data and the tags are held stable while valid && !ready.
- No stall bubble: transfer and emit in the same cycle load the new window with window_valid staying 1. Full throughput is 1 window/cycle.
- frame_sync:
  - Forces x=0, y=0; it does not touch the output register or line buffers.
  - If frame_sync coincides with an accept, that pixel is treated as (0,0) and counters advance to x=1.
  - frame_sync mid-line discards the partial frame.
- Reset mid-operation: any pending window is dropped and counting restarts from (0,0).
- Widths: x-1 and y-1 are computed only when x>=2 and y>=2, so there is no underflow.

Decomposition:
- Shared package grayscale_pkg holds:
  - pix_width default;
  - the window element index function (3r+c);
  - x/y counter width localparams derived via $clog2 from frame_width/frame_lines.
- One sub-module, window_linebuf: a frame_width x pix_width RAM with synchronous write and asynchronous read. It is instantiated twice (lb0, lb1).

Test Plan:
All scenarios use frame_width=8, frame_lines=6, and pixel value (8y+x) mod 256.
1. Continuous ramp, window_ready=1:
   - The first window appears 1 cycle after accepting pixel (2,2), with centre (1,1), rows {0,1,2},{8,9,10},{16,17,18}, and window_sof=1.
   - The frame yields exactly 24 windows.
2. Line boundary: the window from pixel (7,3) has centre (6,2), rows {13,14,15},{21,22,23},{29,30,31}, window_eol=1. The next window has centre (1,3) with eol=0. No window is produced for x<2.
3. End of frame: pixel (7,5) gives centre (6,4), window_eof=1. A second frame starts with no frame_sync, and its first window's sof=1 carries second-frame values.
4. Backpressure: hold window_ready=0 for 5 cycles mid-line.
   - pixel_ready=0 while valid.
   - window_data is unchanged.
   - On release, the windows continue in order with no drop or duplication.
5. frame_sync mid-line at x=4,y=3, then restart the ramp: the first window after resync is at centre (1,1) with sof=1 and contains only new-frame data from lines 0-2.
6. Assert pclk_reset_n low asynchronously (not edge-aligned) while window_valid=1:
   - window_valid drops immediately.
   - After release, pixel_ready=1 and counting restarts at (0,0).

Source files
------------

// File: rtl/grayscale_pkg.sv
// Shared defaults and helpers for the 3x3 grayscale window builder.
package grayscale_pkg;

    localparam int PIX_WIDTH_DEF   = 8;
    localparam int FRAME_WIDTH_DEF = 240;
    localparam int FRAME_LINES_DEF = 480;
    localparam int X_WIDTH_DEF     = $clog2(FRAME_WIDTH_DEF);
    localparam int Y_WIDTH_DEF     = $clog2(FRAME_LINES_DEF);

    function automatic int win_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/grayscale_window_3x3_linebuf.sv
// One line of pixels: synchronous write, asynchronous read, same address.
module window_linebuf #(
    parameter int depth = 240,
    parameter int width = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(depth)-1:0] addr,
    input  logic [width-1:0]         wr_data,
    output logic [width-1:0]         rd_data
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= wr_data;
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/grayscale_window_3x3.sv
// Raster pixel stream in, one registered 3x3 neighbourhood per interior pixel out.
module grayscale_window_3x3
    import grayscale_pkg::*;
#(
    parameter int frame_width = FRAME_WIDTH_DEF,
    parameter int frame_lines = FRAME_LINES_DEF,
    parameter int pix_width   = PIX_WIDTH_DEF
) (
    input  logic                           pclk,
    input  logic                           pclk_reset_n,
    input  logic [pix_width-1:0]           pixel_data,
    input  logic                           pixel_valid,
    output logic                           pixel_ready,
    input  logic                           frame_sync,
    output logic [9*pix_width-1:0]         window_data,
    output logic                           window_valid,
    input  logic                           window_ready,
    output logic [$clog2(frame_width)-1:0] window_x,
    output logic [$clog2(frame_lines)-1:0] window_y,
    output logic                           window_sof,
    output logic                           window_eol,
    output logic                           window_eof
);

    localparam int XW = $clog2(frame_width);
    localparam int YW = $clog2(frame_lines);
    localparam logic [XW-1:0] X_LAST = XW'(frame_width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(frame_lines - 1);

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;
    logic          accept, emit;
    logic [pix_width-1:0] lb0_rd, lb1_rd;

    logic [8:0][pix_width-1:0] arr_q, arr_d;
    logic [8:0][pix_width-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [XW-1:0] wx_q, wx_d;
    logic [YW-1:0] wy_q, wy_d;
    logic          sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;

    assign pixel_ready = !valid_q || window_ready;
    assign accept      = pixel_valid && pixel_ready;

    window_linebuf #(.depth(frame_width), .width(pix_width)) u_lb0 (
        .clk     (pclk),
        .wr_en   (accept),
        .addr    (x_cur),
        .wr_data (pixel_data),
        .rd_data (lb0_rd)
    );

    window_linebuf #(.depth(frame_width), .width(pix_width)) u_lb1 (
        .clk     (pclk),
        .wr_en   (accept),
        .addr    (x_cur),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // frame_sync coinciding with an accept makes that pixel (0,0)
    always_comb begin
        x_cur = frame_sync ? '0 : x_q;
        y_cur = frame_sync ? '0 : y_q;
        x_d   = x_cur;
        y_d   = y_cur;
        if (accept) begin
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
            end else begin
                x_d = x_cur + 1'b1;
            end
        end
    end

    assign emit = accept && (x_cur >= XW'(2)) && (y_cur >= YW'(2));

    always_comb begin
        arr_d = arr_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                arr_d[win_idx(r, 0)] = arr_q[win_idx(r, 1)];
                arr_d[win_idx(r, 1)] = arr_q[win_idx(r, 2)];
            end
            arr_d[win_idx(0, 2)] = lb1_rd;
            arr_d[win_idx(1, 2)] = lb0_rd;
            arr_d[win_idx(2, 2)] = pixel_data;
        end
    end

    // emit wins over a simultaneous transfer so there is no bubble
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        sof_d   = sof_q;
        eol_d   = eol_q;
        eof_d   = eof_q;
        if (emit) begin
            valid_d = 1'b1;
            data_d  = arr_d;
            wx_d    = x_cur - 1'b1;
            wy_d    = y_cur - 1'b1;
            sof_d   = (x_cur == XW'(2)) && (y_cur == YW'(2));
            eol_d   = (x_cur == X_LAST);
            eof_d   = (x_cur == X_LAST) && (y_cur == Y_LAST);
        end else if (valid_q && window_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge pclk_reset_n) begin
        if (!pclk_reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            arr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            arr_q   <= arr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
        end
    end

    assign window_data  = data_q;
    assign window_valid = valid_q;
    assign window_x     = wx_q;
    assign window_y     = wy_q;
    assign window_sof   = sof_q;
    assign window_eol   = eol_q;
    assign window_eof   = eof_q;

endmodule

// File: tb/tb_grayscale_window_3x3.sv
// Directed bench for grayscale_window_3x3 on an 8x6 frame.
module tb_grayscale_window_3x3;

    logic        pclk;
    logic        pclk_reset_n;
    logic [7:0]  pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        frame_sync;
    logic [71:0] window_data;
    logic        window_valid;
    logic        window_ready;
    logic [2:0]  window_x;
    logic [2:0]  window_y;
    logic        window_sof;
    logic        window_eol;
    logic        window_eof;

    grayscale_window_3x3 #(
        .frame_width(8),
        .frame_lines(6),
        .pix_width  (8)
    ) dut (
        .pclk         (pclk),
        .pclk_reset_n (pclk_reset_n),
        .pixel_data   (pixel_data),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .frame_sync   (frame_sync),
        .window_data  (window_data),
        .window_valid (window_valid),
        .window_ready (window_ready),
        .window_x     (window_x),
        .window_y     (window_y),
        .window_sof   (window_sof),
        .window_eol   (window_eol),
        .window_eof   (window_eof)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [71:0] d;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        sof;
        logic        eol;
        logic        eof;
    } win_t;

    int   vectors = 0;
    int   errors  = 0;
    win_t cap[$];
    win_t exp_q[$];
    logic [7:0] img [6][8];
    int   tx = 0;
    int   ty = 0;
    bit   accepted;

    task automatic check(input string tag, input logic [95:0] got,
                         input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic win_t cap_at(input int i);
        win_t w;
        w = '0;
        w.x = 3'h7;
        if (i < cap.size()) w = cap[i];
        return w;
    endfunction

    // Reference: full image store, window taken from rows ty-2..ty, cols tx-2..tx
    task automatic model_accept(input logic [7:0] pd, input logic fs);
        win_t w;
        if (fs) begin
            tx = 0;
            ty = 0;
        end
        img[ty][tx] = pd;
        if (tx >= 2 && ty >= 2) begin
            w = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w.d[8*(3*r+c) +: 8] = img[ty-2+r][tx-2+c];
            w.x   = 3'(tx - 1);
            w.y   = 3'(ty - 1);
            w.sof = (tx == 2 && ty == 2);
            w.eol = (tx == 7);
            w.eof = (tx == 7 && ty == 5);
            exp_q.push_back(w);
        end
        if (tx == 7) begin
            tx = 0;
            ty = (ty == 5) ? 0 : ty + 1;
        end else begin
            tx++;
        end
    endtask

    task automatic observe();
        win_t w, e;
        w.d   = window_data;
        w.x   = window_x;
        w.y   = window_y;
        w.sof = window_sof;
        w.eol = window_eol;
        w.eof = window_eof;
        cap.push_back(w);
        if (exp_q.size() == 0) begin
            check("win_extra", 96'(w), 96'(0) | 96'(1) << 90);
        end else begin
            e = exp_q.pop_front();
            check("win", 96'(w), 96'(e));
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        if (window_valid && window_ready) observe();
        accepted = pixel_valid && pixel_ready;
        @(posedge pclk);
        if (accepted) model_accept(pixel_data, frame_sync);
        else if (frame_sync) begin
            tx = 0;
            ty = 0;
        end
        #1;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            tick();
            n++;
        end
        if (!accepted) check("accept_timeout", 0, 1);
    endtask

    task automatic send_pixels(input int base, input int n,
                               input bit sync_first, input int stall_at);
        logic [71:0] held;
        for (int i = 0; i < n; i++) begin
            pixel_data  = 8'(base + i);
            pixel_valid = 1'b1;
            frame_sync  = sync_first && (i == 0);
            if (i == stall_at) begin
                window_ready = 1'b0;
                held = window_data;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("stall_rdy", 96'(pixel_ready), 0);
                    check("stall_hold", 96'(window_data), 96'(held));
                end
                window_ready = 1'b1;
            end
            wait_accept();
        end
        pixel_valid = 1'b0;
        frame_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        pixel_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        pclk_reset_n = 1'b0;
        pixel_data   = '0;
        pixel_valid  = 1'b0;
        frame_sync   = 1'b0;
        window_ready = 1'b1;
        #2;
        check("rst_valid", 96'(window_valid), 0);
        check("rst_data", 96'(window_data), 0);
        check("rst_tags", 96'({window_x, window_y, window_sof,
                               window_eol, window_eof}), 0);
        check("rst_ready", 96'(pixel_ready), 1);
        #20 pclk_reset_n = 1'b1;
        @(posedge pclk);
        #1;
        check("post_rst_ready", 96'(pixel_ready), 1);

        // frame 1: ramp 8y+x, full throughput
        send_pixels(0, 48, 1'b0, -1);
        idle(2);
        check("f1_count", cap.size(), 24);
        check("f1_first_d", cap_at(0).d, 72'h121110_0A0908_020100);
        check("f1_first_xy", {cap_at(0).x, cap_at(0).y}, {3'd1, 3'd1});
        check("f1_first_sof", cap_at(0).sof, 1);
        check("f1_eol_d", cap_at(11).d, 72'h1F1E1D_171615_0F0E0D);
        check("f1_eol_tag", {cap_at(11).x, cap_at(11).y, cap_at(11).eol},
              {3'd6, 3'd2, 1'b1});
        check("f1_next_tag", {cap_at(12).x, cap_at(12).y, cap_at(12).eol},
              {3'd1, 3'd3, 1'b0});
        check("f1_eof_tag", {cap_at(23).x, cap_at(23).y, cap_at(23).eof},
              {3'd6, 3'd4, 1'b1});

        // frame 2: no frame_sync, offset values, stall before pixel (4,3)
        send_pixels(8'h80, 48, 1'b0, 28);
        idle(2);
        check("f2_count", cap.size(), 48);
        check("f2_first_d", cap_at(24).d, 72'h929190_8A8988_828180);
        check("f2_first_sof", cap_at(24).sof, 1);

        // frame 3 partial up to (3,3), then resync with new ramp
        send_pixels(8'h20, 28, 1'b0, -1);
        send_pixels(8'h40, 48, 1'b1, -1);
        idle(2);
        check("sync_first_d", cap_at(56).d, 72'h525150_4A4948_424140);
        check("sync_first_tag", {cap_at(56).x, cap_at(56).y, cap_at(56).sof},
              {3'd1, 3'd1, 1'b1});

        // reset while a window is pending
        send_pixels(8'h10, 18, 1'b0, -1);
        window_ready = 1'b0;
        send_pixels(8'h10 + 18, 1, 1'b0, -1);
        check("pre_rst_valid", 96'(window_valid), 1);
        #3 pclk_reset_n = 1'b0;
        #1;
        check("async_rst_valid", 96'(window_valid), 0);
        check("async_rst_ready", 96'(pixel_ready), 1);
        exp_q.delete();
        tx = 0;
        ty = 0;
        window_ready = 1'b1;
        #12 pclk_reset_n = 1'b1;
        @(posedge pclk);
        #1;
        check("rst_rel_ready", 96'(pixel_ready), 1);
        send_pixels(8'h60, 24, 1'b0, -1);
        idle(2);
        check("rst_first_d", cap_at(80).d, 72'h727170_6A6968_626160);
        check("rst_first_tag", {cap_at(80).x, cap_at(80).y, cap_at(80).sof},
              {3'd1, 3'd1, 1'b1});
        check("total_count", cap.size(), 86);
        check("pending_exp", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
